// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data-memory responder for the five-stage RISC-V core.
// Models a word-organised RAM with WAIT_CYCLES programmable wait states. Stalls
// the pipeline through BusyM until the access completes, then returns
// sign/zero-extended load data.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   ReqM       M-stage instruction is a load or store
//   WriteEnM   1 = store, 0 = load (qualified by ReqM)
//   Funct3M    access size/sign (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu, others = word)
//   AddrM      byte address (ALUResultM)
//   WriteDataM right-aligned store data
//   ReadDataM  registered load result, held until the next completed load
//   BusyM      stall request toward the hazard unit
//   MisalignM  high in DONE when the completed access was misaligned
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ReqM,
  input  logic        WriteEnM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        BusyM,
  output logic        MisalignM
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam bit          NoWait = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WaitLd = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e        r_state, w_state_next;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [2:0]    r_f3;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH];

  // Operands used at commit. With no wait states the commit edge is also the
  // accept edge, so the live inputs are used instead of the latched copies.
  logic          w_in_idle;
  logic          w_we;
  logic [2:0]    w_f3;
  logic [AW+1:0] w_addr;
  logic [31:0]   w_wdata;
  logic          w_commit;
  logic          w_is_byte, w_is_half, w_is_word, w_signed;
  logic          w_mis;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_lane_data;
  logic [31:0]   w_word;
  logic [31:0]   w_shift;
  logic [31:0]   w_load;
  logic          w_done_mis;

  assign w_in_idle = (r_state == StIdle);
  assign w_we      = w_in_idle ? WriteEnM         : r_we;
  assign w_f3      = w_in_idle ? Funct3M          : r_f3;
  assign w_addr    = w_in_idle ? AddrM[AW+1:0]    : r_addr;
  assign w_wdata   = w_in_idle ? WriteDataM       : r_wdata;

  // Edge entering DONE; gated by reset so nothing commits while it is held.
  assign w_commit = reset &
                    ((w_in_idle & ReqM & NoWait) | ((r_state == StWait) & (r_cnt <= 4'd1)));

  // Funct3[1:0] selects the size; Funct3[2] selects zero-extension.
  assign w_is_byte = (w_f3[1:0] == 2'b00);
  assign w_is_half = (w_f3[1:0] == 2'b01);
  assign w_is_word = ~w_is_byte & ~w_is_half;
  assign w_signed  = ~w_f3[2];
  assign w_mis     = (w_is_half & w_addr[0]) | (w_is_word & (w_addr[1:0] != 2'b00));
  assign w_idx     = w_addr[AW+1:2];

  always_comb begin
    w_be        = 4'b1111;
    w_lane_data = w_wdata;
    if (w_is_byte) begin
      w_be        = 4'b0001 << w_addr[1:0];
      w_lane_data = {4{w_wdata[7:0]}};
    end else if (w_is_half) begin
      w_be        = w_addr[1] ? 4'b1100 : 4'b0011;
      w_lane_data = {2{w_wdata[15:0]}};
    end
  end

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_word;
    if (w_is_byte) begin
      w_load = {{24{w_signed & w_shift[7]}}, w_shift[7:0]};
    end else if (w_is_half) begin
      w_load = {{16{w_signed & w_shift[15]}}, w_shift[15:0]};
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (ReqM) w_state_next = NoWait ? StDone : StWait;
      StWait: if (r_cnt <= 4'd1) w_state_next = StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_in_idle && ReqM) begin
        r_cnt   <= WaitLd;
        r_we    <= WriteEnM;
        r_f3    <= Funct3M;
        r_addr  <= AddrM[AW+1:0];
        r_wdata <= WriteDataM;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit && !w_we) begin
        r_rdata <= w_mis ? 32'd0 : w_load;
      end
    end
  end

  // RAM array has no reset; its contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_we && !w_mis) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
      end
    end
  end

  // In DONE the latched operands always describe the completed access.
  assign w_done_mis = ((r_f3[1:0] == 2'b01) & r_addr[0]) |
                      ((r_f3[1:0] != 2'b00) & (r_f3[1:0] != 2'b01) & (r_addr[1:0] != 2'b00));

  assign ReadDataM = r_rdata;
  assign BusyM     = (w_in_idle & ReqM) | (r_state == StWait);
  assign MisalignM = (r_state == StDone) & w_done_mis;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (2, 0 and 4 wait states) checked
// against a byte-level memory model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic        req [3];
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rd [3];
  logic        busy [3];
  logic        mis [3];

  int          checks = 0;
  int          errors = 0;
  int          wait_of [3] = '{2, 0, 4};

  logic [7:0]  mdl [3][NBYTE];
  logic [31:0] exp_rd [3];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .reset(rst_n[0]), .ReqM(req[0]), .WriteEnM(we), .Funct3M(f3), .AddrM(addr),
    .WriteDataM(wdata), .ReadDataM(rd[0]), .BusyM(busy[0]), .MisalignM(mis[0])
  );
  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .reset(rst_n[1]), .ReqM(req[1]), .WriteEnM(we), .Funct3M(f3), .AddrM(addr),
    .WriteDataM(wdata), .ReadDataM(rd[1]), .BusyM(busy[1]), .MisalignM(mis[1])
  );
  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(4)) u_dut2 (
    .clk(clk), .reset(rst_n[2]), .ReqM(req[2]), .WriteEnM(we), .Funct3M(f3), .AddrM(addr),
    .WriteDataM(wdata), .ReadDataM(rd[2]), .BusyM(busy[2]), .MisalignM(mis[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit misaligned(input logic [2:0] f, input logic [31:0] a);
    return (a % size_of(f)) != 0;
  endfunction

  // Reference load: assemble little-endian bytes, then extend.
  function automatic logic [31:0] model_load(input int i, input logic [2:0] f,
                                             input logic [31:0] a);
    int          n    = size_of(f);
    int          base = int'(a % NBYTE);
    longint      v    = 0;
    for (int k = 0; k < n; k++) v += longint'(mdl[i][base + k]) << (8 * k);
    if (f == 3'd0 && v >= 128)   v -= 256;
    if (f == 3'd1 && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction

  task automatic access(input int i, input bit w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d);
    int cyc;
    bit exp_mis;
    exp_mis = misaligned(f, a);
    if (!exp_mis && w) begin
      for (int k = 0; k < size_of(f); k++) mdl[i][int'(a % NBYTE) + k] = 8'(d >> (8 * k));
    end
    if (!w) exp_rd[i] = exp_mis ? 32'd0 : model_load(i, f, a);

    @(posedge clk); #1;
    req[i] = 1'b1; we = w; f3 = f; addr = a; wdata = d;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!busy[i]) break;
      cyc++;
      if (cyc == 1) check("misalign_idle", {31'd0, mis[i]}, 32'd0);
      if (cyc > 40) break;
    end
    req[i] = 1'b0;
    check("busy_cycles", cyc, wait_of[i] + 1);
    check("misalign_done", {31'd0, mis[i]}, {31'd0, exp_mis});
    check("read_data", rd[i], exp_rd[i]);
  endtask

  task automatic do_reset(input int i);
    @(posedge clk); #1;
    rst_n[i] = 1'b0;
    req[i]   = 1'b0;
    @(negedge clk);
    exp_rd[i] = 32'd0;
    check("rst_rdata", rd[i], 32'd0);
    check("rst_mis", {31'd0, mis[i]}, 32'd0);
    check("rst_busy", {31'd0, busy[i]}, 32'd0);
    @(posedge clk); #1;
    rst_n[i] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req[i] = 1'b0; exp_rd[i] = 32'd0;
      for (int b = 0; b < NBYTE; b++) mdl[i][b] = 8'h00;
    end
    we = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Preload word 5, reset, then a word load across the reset.
    access(0, 1'b1, 3'd2, 32'h14, 32'hDEADBEEF);
    do_reset(0);
    access(0, 1'b0, 3'd2, 32'h14, 32'h0);
    check("lw_deadbeef", rd[0], 32'hDEADBEEF);

    // Extension.
    access(0, 1'b1, 3'd2, 32'h0, 32'h80F17F01);
    access(0, 1'b0, 3'd0, 32'h3, 32'h0); check("lb3", rd[0], 32'hFFFFFF80);
    access(0, 1'b0, 3'd4, 32'h3, 32'h0); check("lbu3", rd[0], 32'h00000080);
    access(0, 1'b0, 3'd1, 32'h2, 32'h0); check("lh2", rd[0], 32'hFFFF80F1);
    access(0, 1'b0, 3'd5, 32'h2, 32'h0); check("lhu2", rd[0], 32'h000080F1);
    access(0, 1'b0, 3'd0, 32'h1, 32'h0); check("lb1", rd[0], 32'h0000007F);

    // Partial stores into a zeroed word.
    access(0, 1'b1, 3'd2, 32'h8, 32'h0);
    access(0, 1'b1, 3'd0, 32'h9, 32'hFFFFFFAB);
    access(0, 1'b1, 3'd1, 32'hA, 32'hFFFF1234);
    access(0, 1'b0, 3'd2, 32'h8, 32'h0); check("partial", rd[0], 32'h1234AB00);

    // Misalignment; the following access also confirms the flag lasted one cycle.
    access(0, 1'b0, 3'd2, 32'h2, 32'h0); check("mis_lw", rd[0], 32'h0);
    access(0, 1'b1, 3'd2, 32'h4, 32'h11223344);
    access(0, 1'b1, 3'd1, 32'h5, 32'h0000BEEF);
    access(0, 1'b0, 3'd2, 32'h4, 32'h0); check("mis_sh", rd[0], 32'h11223344);

    // Zero wait states, back-to-back.
    access(1, 1'b1, 3'd2, 32'h40, 32'h55);
    access(1, 1'b0, 3'd2, 32'h40, 32'h0); check("b2b", rd[1], 32'h55);

    // Reset in WAIT with the counter at 2 aborts the pending store.
    access(2, 1'b1, 3'd2, 32'h8, 32'h11112222);
    @(posedge clk); #1;
    req[2] = 1'b1; we = 1'b1; f3 = 3'd2; addr = 32'h8; wdata = 32'hCAFE;
    repeat (3) @(posedge clk);
    #1;
    rst_n[2] = 1'b0;
    req[2]   = 1'b0;
    @(negedge clk);
    exp_rd[2] = 32'd0;
    check("abort_busy", {31'd0, busy[2]}, 32'd0);
    check("abort_rdata", rd[2], 32'd0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    access(2, 1'b0, 3'd2, 32'h8, 32'h0); check("abort_prior", rd[2], 32'h11112222);
    access(2, 1'b0, 3'd2, 32'h8 + 4 * DEPTH, 32'h0); check("alias", rd[2], 32'h11112222);

    // Random traffic over words 0..15 with random upper (aliasing) address bits.
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 16; w++) access(i, 1'b1, 3'd2, 32'(4 * w), $urandom);
      for (int n = 0; n < 50; n++) begin
        access(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 63)), $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
